// File: rtl/i2s_sample_serializer_if.sv
// Sample push bus between the mixer and the I2S output stage.
// The mixer drives SampleIn/SampleValid; the serializer answers with SampleReady.
`timescale 1ns/1ps
interface i2s_sample_serializer_if;
    logic [31:0] SampleIn;
    logic        SampleValid;
    logic        SampleReady;

    modport master (output SampleIn, output SampleValid, input SampleReady);
    modport slave  (input SampleIn, input SampleValid, output SampleReady);
endinterface

// File: rtl/i2s_sample_serializer.sv
// Stereo sample FIFO feeding a Philips I2S transmitter (16-bit slots, 32 BCLK/frame).
// Define I2S_UNDERRUN_HOLD_EN to repeat the previous frame on underrun instead of sending silence.
`timescale 1ns/1ps
module i2s_sample_serializer #(
    parameter int CLK_DIV    = 35,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          MasterCLK,
    input  logic                          Reset,
    input  logic                          Enable,
    i2s_sample_serializer_if.slave        smp,
    output logic                          SampleRequest,
    output logic [$clog2(FIFO_DEPTH):0]   FifoLevel,
    output logic [7:0]                    UnderrunCount,
    output logic                          I2S_CLK,
    output logic                          I2S_WS,
    output logic                          I2S_DATA
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [AW:0]      LVL_FULL = (AW + 1)'(FIFO_DEPTH);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [31:0]      fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [DIV_W-1:0] div_cnt;
    logic [4:0]       slot;
    logic [31:0]      frame;

    logic             div_tc;
    logic             fall_evt;
    logic [4:0]       slot_nxt;
    logic [4:0]       bit_idx;
    logic             frame_start;
    logic             fifo_empty;
    logic             push;
    logic             pop;

    assign smp.SampleReady = (FifoLevel != LVL_FULL);
    assign div_tc          = (div_cnt == DIV_LAST);
    assign fall_evt        = Enable & div_tc & I2S_CLK;
    assign slot_nxt        = slot + 5'd1;
    // Slot s carries frame bit 32-s; slot 0 wraps to bit 0 of the outgoing frame.
    assign bit_idx         = 5'd0 - slot_nxt;
    assign frame_start     = fall_evt & (slot_nxt == 5'd0);
    assign fifo_empty      = (FifoLevel == '0);
    assign push            = smp.SampleValid & smp.SampleReady;
    assign pop             = frame_start & ~fifo_empty;

    // FIFO storage: contents need no reset, pointers/level define validity.
    always_ff @(posedge MasterCLK) begin
        if (push) begin
            fifo_mem[wr_ptr] <= smp.SampleIn;
        end
    end

    always_ff @(posedge MasterCLK or negedge Reset) begin
        if (!Reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            FifoLevel <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   FifoLevel <= FifoLevel + 1'b1;
                2'b01:   FifoLevel <= FifoLevel - 1'b1;
                default: FifoLevel <= FifoLevel;
            endcase
        end
    end

    // Bit clock divider, slot sequencing and frame loading.
    always_ff @(posedge MasterCLK or negedge Reset) begin
        if (!Reset) begin
            div_cnt       <= '0;
            I2S_CLK       <= 1'b0;
            slot          <= 5'd31;
            I2S_WS        <= 1'b0;
            I2S_DATA      <= 1'b0;
            frame         <= '0;
            SampleRequest <= 1'b0;
            UnderrunCount <= '0;
        end else if (!Enable) begin
            div_cnt       <= '0;
            I2S_CLK       <= 1'b0;
            slot          <= 5'd31;
            I2S_WS        <= 1'b0;
            I2S_DATA      <= 1'b0;
            frame         <= '0;
            SampleRequest <= 1'b0;
        end else begin
            SampleRequest <= pop;
            if (div_tc) begin
                div_cnt <= '0;
                I2S_CLK <= ~I2S_CLK;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
            if (fall_evt) begin
                slot     <= slot_nxt;
                I2S_WS   <= slot_nxt[4];
                I2S_DATA <= frame[bit_idx];
                if (frame_start) begin
                    if (!fifo_empty) begin
                        frame <= fifo_mem[rd_ptr];
                    end else begin
`ifdef I2S_UNDERRUN_HOLD_EN
                        frame <= frame;
`else
                        frame <= '0;
`endif
                        UnderrunCount <= sat_inc(UnderrunCount);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_sample_serializer.sv
// Directed bench for i2s_sample_serializer at CLK_DIV=2, FIFO_DEPTH=4 (frame = 128 clocks).
// Frame expectations follow I2S_UNDERRUN_HOLD_EN when it is defined.
`timescale 1ns/1ps
module tb_i2s_sample_serializer;

    logic       MasterCLK = 1'b0;
    logic       Reset;
    logic       Enable;
    logic       SampleRequest;
    logic [2:0] FifoLevel;
    logic [7:0] UnderrunCount;
    logic       I2S_CLK;
    logic       I2S_WS;
    logic       I2S_DATA;

    i2s_sample_serializer_if bus ();

    i2s_sample_serializer #(.CLK_DIV(2), .FIFO_DEPTH(4)) dut (
        .MasterCLK     (MasterCLK),
        .Reset         (Reset),
        .Enable        (Enable),
        .smp           (bus),
        .SampleRequest (SampleRequest),
        .FifoLevel     (FifoLevel),
        .UnderrunCount (UnderrunCount),
        .I2S_CLK       (I2S_CLK),
        .I2S_WS        (I2S_WS),
        .I2S_DATA      (I2S_DATA)
    );

    always #5 MasterCLK = ~MasterCLK;

`ifdef I2S_UNDERRUN_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    localparam logic [31:0] WS_PATTERN = 32'hFFFF_0000;

    typedef struct {
        logic        early_push;
        logic        late_push;
        logic [31:0] push_word;
        logic        exp_req;
        logic [2:0]  exp_level;
        logic [7:0]  exp_under;
        logic [31:0] exp_word;
    } vec_t;

    vec_t        tbl [10];
    logic [31:0] words [5];
    int          n_vec = 0;
    int          n_bad = 0;

    task automatic step(input int n);
        repeat (n) @(negedge MasterCLK);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic e, input logic l, input logic [31:0] w,
                                 input logic rq, input logic [2:0] lv, input logic [7:0] un,
                                 input logic [31:0] xw);
        vec_t v;
        v.early_push = e;  v.late_push = l;  v.push_word = w;
        v.exp_req    = rq; v.exp_level = lv; v.exp_under = un; v.exp_word = xw;
        return v;
    endfunction

    function automatic logic [31:0] und(input logic [31:0] held);
        return HOLD ? held : 32'h0;
    endfunction

    // Frame bits 31..1 live in slots 1..31; bit 0 arrives in the next frame's slot 0.
    function automatic logic [31:0] hi_bits(input logic [31:0] d);
        logic [31:0] r;
        r = '0;
        for (int s = 1; s < 32; s++) r[32 - s] = d[s];
        return r;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, {31'h0, bus.SampleReady}, 32'd1);
        chk({tag, "_req"},   {31'h0, SampleRequest},   32'd0);
        chk({tag, "_level"}, {29'h0, FifoLevel},       32'd0);
        chk({tag, "_under"}, {24'h0, UnderrunCount},   32'd0);
        chk({tag, "_bclk"},  {31'h0, I2S_CLK},         32'd0);
        chk({tag, "_ws"},    {31'h0, I2S_WS},          32'd0);
        chk({tag, "_data"},  {31'h0, I2S_DATA},        32'd0);
    endtask

    // Starts one clock after a frame start; ends one clock after the next frame start.
    task automatic run_frame(input logic early, input logic late, input logic [31:0] w,
                             output logic [31:0] d, output logic [31:0] ws, output logic clk_bad);
        clk_bad = 1'b0;
        d  = '0;
        ws = '0;
        for (int s = 0; s < 32; s++) begin
            if (s == 0 && early) begin
                bus.SampleValid = 1'b1; bus.SampleIn = w;
                step(1);
                bus.SampleValid = 1'b0;
                step(1);
            end else begin
                step(2);
            end
            if (I2S_CLK !== 1'b1) clk_bad = 1'b1;
            d[s]  = I2S_DATA;
            ws[s] = I2S_WS;
            if (s == 31 && late) begin
                step(1);
                bus.SampleValid = 1'b1; bus.SampleIn = w;
                step(1);
                bus.SampleValid = 1'b0;
            end else begin
                step(2);
            end
            if (I2S_CLK !== 1'b0) clk_bad = 1'b1;
        end
    endtask

    initial begin
        logic [31:0] d, ws, hi, prev_hi;
        logic        cb, req_seen;
        logic [31:0] y1, z;

        words[0] = 32'hA5A5_3C3C;
        words[1] = 32'h1234_5678;
        words[2] = 32'h8000_0001;
        words[3] = 32'hFFFF_0000;
        words[4] = 32'hDEAD_BEEF;

        tbl[0] = mkv(0, 0, 32'h0,         1, 3'd3, 8'd0, words[0]);
        tbl[1] = mkv(0, 0, 32'h0,         1, 3'd2, 8'd0, words[1]);
        tbl[2] = mkv(0, 0, 32'h0,         1, 3'd1, 8'd0, words[2]);
        tbl[3] = mkv(0, 0, 32'h0,         1, 3'd0, 8'd0, words[3]);
        tbl[4] = mkv(1, 0, 32'h8001_7FFE, 0, 3'd0, 8'd1, und(words[3]));
        tbl[5] = mkv(0, 0, 32'h0,         1, 3'd0, 8'd1, 32'h8001_7FFE);
        tbl[6] = mkv(0, 0, 32'h0,         0, 3'd0, 8'd2, und(32'h8001_7FFE));
        tbl[7] = mkv(0, 1, 32'h0F0F_F0F0, 0, 3'd0, 8'd3, und(32'h8001_7FFE));
        tbl[8] = mkv(0, 0, 32'h0,         0, 3'd1, 8'd4, und(32'h8001_7FFE));
        tbl[9] = mkv(0, 0, 32'h0,         1, 3'd0, 8'd4, 32'h0F0F_F0F0);

        Reset = 1'b0; Enable = 1'b0;
        bus.SampleValid = 1'b0; bus.SampleIn = '0;
        step(3);
        check_reset_outputs("rst");
        Reset = 1'b1;
        step(1);

        // Prefill while idle: fifth push must be refused.
        for (int k = 0; k < 5; k++) begin
            chk("prefill_ready", {31'h0, bus.SampleReady}, (k < 4) ? 32'd1 : 32'd0);
            bus.SampleValid = 1'b1; bus.SampleIn = words[k];
            step(1);
        end
        bus.SampleValid = 1'b0;
        chk("prefill_level", {29'h0, FifoLevel}, 32'd4);
        chk("idle_bclk",     {31'h0, I2S_CLK},   32'd0);

        Enable = 1'b1;
        step(4);
        prev_hi = '0;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("v%0d_req", i),   {31'h0, SampleRequest}, {31'h0, tbl[i].exp_req});
            chk($sformatf("v%0d_level", i), {29'h0, FifoLevel},     {29'h0, tbl[i].exp_level});
            chk($sformatf("v%0d_under", i), {24'h0, UnderrunCount}, {24'h0, tbl[i].exp_under});
            run_frame(tbl[i].early_push, tbl[i].late_push, tbl[i].push_word, d, ws, cb);
            chk($sformatf("v%0d_ws", i),   ws, WS_PATTERN);
            chk($sformatf("v%0d_bclk", i), {31'h0, cb}, 32'd0);
            if (i > 0) chk($sformatf("v%0d_word", i - 1), {prev_hi[31:1], d[0]}, tbl[i - 1].exp_word);
            prev_hi = hi_bits(d);
        end
        step(2);
        chk("v9_word", {prev_hi[31:1], I2S_DATA}, tbl[9].exp_word);
        step(126);

        // Long starvation: counter saturates and no request ever pulses.
        req_seen = 1'b0;
        repeat (260 * 128) begin
            step(1);
            if (SampleRequest) req_seen = 1'b1;
        end
        chk("starve_req",   {31'h0, req_seen},      32'd0);
        chk("starve_under", {24'h0, UnderrunCount}, 32'd255);

        // Full FIFO with SampleValid held across the pop.
        for (int k = 0; k < 4; k++) begin
            bus.SampleValid = 1'b1; bus.SampleIn = 32'h1111_1111 * (k + 1);
            step(1);
        end
        bus.SampleIn = 32'h5555_5555;
        step(123);
        chk("full_level_pre", {29'h0, FifoLevel},     32'd4);
        chk("full_ready_pre", {31'h0, bus.SampleReady}, 32'd0);
        step(1);
        chk("full_pop_req",   {31'h0, SampleRequest}, 32'd1);
        chk("full_pop_level", {29'h0, FifoLevel},     32'd3);
        step(1);
        chk("full_refill",    {29'h0, FifoLevel},     32'd4);
        bus.SampleValid = 1'b0;

        // Disable mid-frame at slot 20.
        step(81);
        chk("slot20_ws", {31'h0, I2S_WS}, 32'd1);
        Enable = 1'b0;
        step(1);
        chk("dis_bclk",  {31'h0, I2S_CLK},       32'd0);
        chk("dis_ws",    {31'h0, I2S_WS},        32'd0);
        chk("dis_data",  {31'h0, I2S_DATA},      32'd0);
        chk("dis_level", {29'h0, FifoLevel},     32'd4);
        step(10);
        chk("dis_hold_bclk",  {31'h0, I2S_CLK},       32'd0);
        chk("dis_hold_under", {24'h0, UnderrunCount}, 32'd255);
        Enable = 1'b1;
        step(4);
        chk("reen_req",   {31'h0, SampleRequest}, 32'd1);
        chk("reen_level", {29'h0, FifoLevel},     32'd3);
        chk("reen_ws",    {31'h0, I2S_WS},        32'd0);
        chk("reen_data",  {31'h0, I2S_DATA},      32'd0);
        run_frame(1'b0, 1'b0, 32'h0, d, ws, cb);
        y1 = 32'h2222_2222;
        hi = hi_bits(d);
        chk("reen_word_hi", {hi[31:1], 1'b0}, {y1[31:1], 1'b0});
        chk("reen_ws_pat",  ws, WS_PATTERN);
        chk("next_level",   {29'h0, FifoLevel}, 32'd2);

        // Asynchronous reset at slot 10.
        step(41);
        Reset = 1'b0;
        #1;
        check_reset_outputs("midrst");
        step(1);
        z = 32'hC0DE_0FF1;
        Reset = 1'b1;
        bus.SampleValid = 1'b1; bus.SampleIn = z;
        step(1);
        bus.SampleValid = 1'b0;
        chk("post_rst_level", {29'h0, FifoLevel}, 32'd1);
        step(3);
        chk("post_rst_req",   {31'h0, SampleRequest}, 32'd1);
        chk("post_rst_empty", {29'h0, FifoLevel},     32'd0);
        run_frame(1'b0, 1'b0, 32'h0, d, ws, cb);
        hi = hi_bits(d);
        step(2);
        chk("post_rst_word", {hi[31:1], I2S_DATA}, z);
        chk("post_rst_bclk", {31'h0, cb}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
